fnv_cmd_frontend: RTL and testbench
===================================

Name: fnv_cmd_frontend

Overview:
- Command/framing stage between the I2C target byte interface and the fnv_1a_32 hasher.
- Decodes a byte-stream protocol arriving from the I2C receiver and drives the hasher's reset, enable and byte inputs.
- Snapshots the 32-bit hash result and serves it back to the I2C transmitter as 4 bytes, MSB first.

Parameters:
- OffsetBasis, 32'h811C9DC5, snapshot register reset value; matches the hasher's reset state.
- CmdReset, 8'h01, opcode: reset the hash.
- CmdData, 8'h02, opcode: a length byte N follows, then N data bytes.
- CmdSnap, 8'h03, opcode: latch the current hash for readout.
- CmdClrErr, 8'h04, opcode: clear the sticky error flag.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte
- rx_data  in  8  received byte
- rx_stop  in  1  one-cycle strobe on I2C STOP
- tx_req  in  1  one-cycle strobe; transmitter consumed tx_data
- tx_data  out  8  current readout byte
- hash_in  in  32  hasher output
- hash_reset  out  1  to hasher reset
- hash_enable  out  1  to hasher enable
- hash_byte  out  8  to hasher in
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky protocol error flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Values while reset is asserted and on the first cycle after release:
  - hash_reset=1
  - hash_enable=0, hash_byte=0
  - err=0, busy=0
  - snapshot=OffsetBasis, read index=0, so tx_data=8'h81
  - state=IDLE
- hash_reset returns to 0 on the first cycle after reset deasserts.
- States: IDLE, LEN, DATA, SNAP.
- IDLE, on rx_valid, decode rx_data:
  - CmdReset: hash_reset=1 for exactly one cycle; stay in IDLE.
  - CmdData: go to LEN.
  - CmdSnap: go to SNAP.
  - CmdClrErr: err<=0.
  - Any other value: err<=1; stay in IDLE.
- LEN, on rx_valid:
  - remaining<=rx_data.
  - If rx_data==0, go to IDLE; otherwise go to DATA.
- DATA, on rx_valid:
  - hash_enable=1 and hash_byte=rx_data for exactly one cycle (the cycle after the strobe).
  - remaining decrements; on reaching 0, go to IDLE.
  - Data bytes are never decoded as opcodes.
- SNAP: a single-cycle state.
  - snapshot<=hash_in, read index<=0, then go to IDLE.
  - Any rx_valid in this cycle is accepted as an IDLE-decoded byte in the same cycle.
- Latency:
  - Hasher state reflects a data byte 2 edges after its rx_valid.
  - SNAP capture happens 2 edges after the CmdSnap rx_valid.
  - So CmdSnap arriving back-to-back, on the cycle right after the last data strobe, still captures the updated hash.
- Readout:
  - tx_data = snapshot byte[3-idx], i.e. idx 0 → bits [31:24].
  - tx_req increments idx; idx wraps 3→0.
  - A SNAP capture resetting idx to 0 overrides a tx_req in the same cycle.
- rx_stop:
  - In LEN, or in DATA with remaining>0: err<=1 and go to IDLE.
  - Abort does not reset the hash.
  - In IDLE: no effect.
  - rx_valid and rx_stop in the same cycle: the byte is processed first, and the stop is evaluated against the post-byte state. A stop arriving with the final data byte is not an error.
- remaining is 8 bits, so a frame carries at most 255 data bytes.
- err persists until CmdClrErr or reset.
- reset mid-frame: immediate return to IDLE with all reset values; hash_reset=1 restarts the hasher.

Test Plan:
- Reset, then 4×tx_req → tx_data sequence 81,1C,9D,C5 → idx back to 0.
- Bytes 01,02,01,61,03, then 4×tx_req → 0xE40C292C read as E4,0C,29,2C; err=0.
- Bytes 01,02,06,"foobar",03 back-to-back (rx_valid every cycle) → snapshot 0xBF9CF968; hash_enable high for exactly 6 cycles.
- Bytes 02,03,61 then rx_stop → err=1, state IDLE, hash has absorbed 0x61; then 04 → err=0.
- Byte 0x7F in IDLE → err=1. Then 02,00 → no hash_enable pulse, busy drops after the length byte.
- Reset asserted while in DATA with 3 bytes remaining → next cycle all outputs at reset values. A following 01,03 snapshot reads 0x811C9DC5.

Source files
------------

// File: rtl/fnv_cmd_frontend.sv
// Command/framing front end for the FNV-1a hasher.
// Decodes the I2C receive byte stream (reset / data frame / snapshot /
// clear-error), drives the hasher inputs, and serves a latched 32-bit hash
// back to the I2C transmitter one byte at a time, MSB first.
module fnv_cmd_frontend #(
    parameter logic [31:0] OffsetBasis = 32'h811C9DC5,
    parameter logic [7:0]  CmdReset    = 8'h01,
    parameter logic [7:0]  CmdData     = 8'h02,
    parameter logic [7:0]  CmdSnap     = 8'h03,
    parameter logic [7:0]  CmdClrErr   = 8'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_stop,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic [31:0] hash_in,
    output logic        hash_reset,
    output logic        hash_enable,
    output logic [7:0]  hash_byte,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_SNAP = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  remaining_r, remaining_s;
    logic        err_r, err_s;
    logic [31:0] snapshot_r, snapshot_s;
    logic [1:0]  idx_r, idx_s;
    logic [7:0]  tx_data_r, tx_data_s;
    logic        hash_reset_r, hash_reset_s;
    logic        hash_enable_r, hash_enable_s;
    logic [7:0]  hash_byte_r, hash_byte_s;
    logic        busy_r;

    // Byte idx of the snapshot, idx 0 being the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Next-state, frame bookkeeping, hasher drive and readout selection.
    always_comb begin
        state_s       = state_r;
        remaining_s   = remaining_r;
        err_s         = err_r;
        snapshot_s    = snapshot_r;
        hash_reset_s  = 1'b0;
        hash_enable_s = 1'b0;
        hash_byte_s   = 8'h00;
        if (tx_req) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end

        case (state_r)
            ST_IDLE, ST_SNAP: begin
                // SNAP lasts one cycle; a byte arriving during it is decoded
                // exactly as in IDLE, and the capture wins over tx_req.
                if (state_r == ST_SNAP) begin
                    snapshot_s = hash_in;
                    idx_s      = 2'd0;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
                if (rx_valid) begin
                    case (rx_data)
                        CmdReset:  hash_reset_s = 1'b1;
                        CmdData:   state_s      = ST_LEN;
                        CmdSnap:   state_s      = ST_SNAP;
                        CmdClrErr: err_s        = 1'b0;
                        default:   err_s        = 1'b1;
                    endcase
                end else begin
                    hash_reset_s = 1'b0;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    remaining_s = rx_data;
                    if (rx_data == 8'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                // Payload bytes go straight to the hasher, never decoded.
                if (rx_valid) begin
                    hash_enable_s = 1'b1;
                    hash_byte_s   = rx_data;
                    remaining_s   = remaining_r - 8'd1;
                    if (remaining_r == 8'd1) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // STOP is judged after the byte of the same cycle: only a frame that
        // is still open (length pending or payload outstanding) is aborted.
        if (rx_stop && ((state_s == ST_LEN) || (state_s == ST_DATA))) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
        end else begin
            err_s = err_s;
        end

        tx_data_s = byte_sel(snapshot_s, idx_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            remaining_r   <= 8'd0;
            err_r         <= 1'b0;
            snapshot_r    <= OffsetBasis;
            idx_r         <= 2'd0;
            tx_data_r     <= OffsetBasis[31:24];
            hash_reset_r  <= 1'b1;
            hash_enable_r <= 1'b0;
            hash_byte_r   <= 8'h00;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            remaining_r   <= remaining_s;
            err_r         <= err_s;
            snapshot_r    <= snapshot_s;
            idx_r         <= idx_s;
            tx_data_r     <= tx_data_s;
            hash_reset_r  <= hash_reset_s;
            hash_enable_r <= hash_enable_s;
            hash_byte_r   <= hash_byte_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign tx_data     = tx_data_r;
    assign hash_reset  = hash_reset_r;
    assign hash_enable = hash_enable_r;
    assign hash_byte   = hash_byte_r;
    assign busy        = busy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_fnv_cmd_frontend.sv
// Testbench for fnv_cmd_frontend: a behavioural FNV-1a hasher sits on the
// hash_* port; a protocol-level model predicts hasher bytes and readout bytes
// into queues, and a monitor compares them as the DUT presents them.
module tb_fnv_cmd_frontend;

    localparam logic [31:0] BASIS = 32'h811C9DC5;
    localparam logic [31:0] PRIME = 32'h01000193;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stop = 1'b0;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_data;
    logic [31:0] hash_in;
    logic        hash_reset;
    logic        hash_enable;
    logic [7:0]  hash_byte;
    logic        busy;
    logic        err;

    fnv_cmd_frontend dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_stop    (rx_stop),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .hash_in    (hash_in),
        .hash_reset (hash_reset),
        .hash_enable(hash_enable),
        .hash_byte  (hash_byte),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Environment: behavioural fnv_1a_32 hasher.
    logic [31:0] hasher_q;
    always @(posedge clk) begin
        if (hash_reset) hasher_q <= BASIS;
        else if (hash_enable) hasher_q <= (hasher_q ^ {24'h0, hash_byte}) * PRIME;
    end
    assign hash_in = hasher_q;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    logic [7:0] exp_byte_q[$];
    logic [7:0] exp_tx_q[$];

    // Protocol-level reference model
    logic [31:0] m_hash, m_snap;
    int          m_idx;
    bit          m_err;
    bit          m_want_len;
    int          m_left;

    function automatic logic [31:0] fnv_step(logic [31:0] h, logic [7:0] b);
        return (h ^ {24'h0, b}) * PRIME;
    endfunction

    function automatic logic [7:0] word_byte(logic [31:0] w, int i);
        return w[8*(3-i) +: 8];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hash = BASIS; m_snap = BASIS; m_idx = 0; m_err = 1'b0;
        m_want_len = 1'b0; m_left = 0;
        exp_byte_q.delete();
        exp_tx_q.delete();
    endtask

    task automatic model_byte(logic [7:0] b);
        if (m_want_len) begin
            m_want_len = 1'b0;
            m_left = int'(b);
        end else if (m_left > 0) begin
            exp_byte_q.push_back(b);
            m_hash = fnv_step(m_hash, b);
            m_left--;
        end else begin
            case (b)
                8'h01: m_hash = BASIS;
                8'h02: m_want_len = 1'b1;
                8'h03: begin m_snap = m_hash; m_idx = 0; end
                8'h04: m_err = 1'b0;
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic model_stop();
        if (m_want_len || m_left > 0) begin
            m_err = 1'b1; m_want_len = 1'b0; m_left = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, bit stop = 1'b0);
        rx_valid = 1'b1; rx_data = b; rx_stop = stop;
        model_byte(b);
        if (stop) model_stop();
        tick();
        rx_valid = 1'b0; rx_stop = 1'b0;
    endtask

    task automatic stop_only();
        rx_stop = 1'b1;
        model_stop();
        tick();
        rx_stop = 1'b0;
    endtask

    task automatic read();
        tx_req = 1'b1;
        exp_tx_q.push_back(word_byte(m_snap, m_idx));
        m_idx = (m_idx + 1) % 4;
        tick();
        tx_req = 1'b0;
    endtask

    task automatic read_const(logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            tx_req = 1'b1;
            exp_tx_q.push_back(word_byte(w, i));
            m_idx = (m_idx + 1) % 4;
            tick();
        end
        tx_req = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic settle();
        tick(); tick();
        check("err", err, m_err);
        check("busy", busy, (m_want_len || m_left > 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        check("rst_hash_reset", hash_reset, 1);
        check("rst_hash_enable", hash_enable, 0);
        check("rst_hash_byte", hash_byte, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 8'h81);
        tick();
        check("hash_reset_release", hash_reset, 0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (hash_enable) begin
                    en_cnt++;
                    if (exp_byte_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL hash_byte: unexpected enable with %h, none expected", hash_byte);
                    end else check("hash_byte", hash_byte, exp_byte_q.pop_front());
                end
                if (tx_req) begin
                    if (exp_tx_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_data: read of %h, none expected", tx_data);
                    end else check("tx_data", tx_data, exp_tx_q.pop_front());
                end
            end
        end
    endtask

    task automatic run_all();
        int en0;
        logic [31:0] p_snap;
        int p_idx;
        logic [7:0] foobar[6];
        foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};

        // Reset readout and idx wrap
        do_reset();
        read_const(BASIS);
        read();
        read(); read(); read();

        // Hash of "a"
        send(8'h01); send(8'h02); send(8'h01); send(8'h61); send(8'h03);
        settle();
        read_const(32'hE40C292C);

        // "foobar" back-to-back, snapshot right after last data byte
        en0 = en_cnt;
        send(8'h01); send(8'h02); send(8'h06);
        for (int i = 0; i < 6; i++) send(foobar[i]);
        send(8'h03);
        settle();
        check("enable_cycles", en_cnt - en0, 6);
        read_const(32'hBF9CF968);

        // Snapshot capture overrides a simultaneous tx_req
        read();
        p_snap = m_snap; p_idx = m_idx;
        send(8'h03);
        tx_req = 1'b1;
        exp_tx_q.push_back(word_byte(p_snap, p_idx));
        tick();
        tx_req = 1'b0;
        tick();
        read_const(32'hBF9CF968);

        // Abort mid-frame keeps absorbed bytes; clear error
        send(8'h01);
        send(8'h02); send(8'h03); send(8'h61);
        stop_only();
        settle();
        check("abort_err", err, 1);
        send(8'h04);
        settle();
        send(8'h03);
        settle();
        read_const(32'hE40C292C);

        // Stop together with the final data byte is not an error
        send(8'h02); send(8'h01); send(8'h5A, 1'b1);
        settle();

        // Unknown opcode, then a zero-length frame
        send(8'h7F);
        settle();
        en0 = en_cnt;
        send(8'h02);
        check("busy_len", busy, 1);
        send(8'h00);
        check("busy_after_len0", busy, 0);
        settle();
        check("len0_no_enable", en_cnt - en0, 0);

        // Reset in the middle of a data frame
        send(8'h02); send(8'h05); send(8'hAA); send(8'hBB);
        tick();
        do_reset();
        send(8'h01); send(8'h03);
        settle();
        read_const(BASIS);

        // Randomized command mix
        for (int op = 0; op < 150; op++) begin
            int kind, len, k, n;
            kind = $urandom_range(0, 7);
            case (kind)
                0: send(8'h01);
                1, 2: begin
                    len = $urandom_range(0, 8);
                    send(8'h02); gap(); send(8'(len)); gap();
                    for (int i = 0; i < len; i++) begin
                        send(8'($urandom), (i == len - 1) && ($urandom_range(0, 3) == 0));
                        gap();
                    end
                end
                3: begin
                    send(8'h03); settle();
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) read();
                end
                4: send(8'h04);
                5: send(8'($urandom));
                6: begin
                    len = $urandom_range(1, 8);
                    k = $urandom_range(0, len - 1);
                    send(8'h02); gap(); send(8'(len));
                    for (int i = 0; i < k; i++) begin
                        gap();
                        send(8'($urandom), (i == k - 1) && ($urandom_range(0, 1) == 1));
                    end
                    if (m_want_len || m_left > 0) stop_only();
                end
                default: begin
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) read();
                end
            endcase
            settle();
        end
        repeat (4) tick();
    endtask

    initial begin
        model_reset();
        fork
            monitor();
            run_all();
        join_any
        disable fork;
        check("byte_queue_drained", exp_byte_q.size(), 0);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
